// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: one outstanding read at a time feeding a DEPTH-entry FIFO.
// Define IFETCH_PERF_EN to add the flush_cnt_o counter output.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        ins_ready_i,
  output logic        ins_valid_o,
  output logic [31:0] ins_data_o,
  output logic [31:0] ins_pc_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_after_pop, cnt_after;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [31:0]             fetch_pc_q, fetch_pc_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic                    mem_req_q;
  logic [DEPTH-1:0][31:0]  data_q, pc_q;
  logic                    pop, push;

  assign ins_valid_o = (cnt_q != '0);
  assign ins_data_o  = ins_valid_o ? data_q[rd_ptr_q] : '0;
  assign ins_pc_o    = ins_valid_o ? pc_q[rd_ptr_q]   : '0;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;

  assign pop           = ins_valid_o & ins_ready_i;
  assign cnt_after_pop = cnt_q - CW'(pop);
  assign push          = (state_q == REQ) & mem_ack_i & ~redirect_valid_i &
                         (cnt_after_pop < DEPTH_C);
  assign cnt_after     = cnt_after_pop + CW'(push);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (!redirect_valid_i && (cnt_after_pop < DEPTH_C)) begin
          state_d    = REQ;
          mem_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect_valid_i) begin
          state_d = mem_ack_i ? IDLE : DRAIN;
        end else if (mem_ack_i) begin
          fetch_pc_d = mem_addr_q + 32'd4;
          if (cnt_after < DEPTH_C) begin
            mem_addr_d = mem_addr_q + 32'd4;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        // The stale read must retire before a new address may be issued.
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid_i) fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '0;
      pc_q     <= '0;
    end else if (redirect_valid_i) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q <= cnt_after;
      if (push) begin
        data_q[wr_ptr_q] <= mem_rdata_i;
        pc_q[wr_ptr_q]   <= mem_addr_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

`ifdef IFETCH_PERF_EN
  // A redirect in REQ always kills the pending read; in DRAIN it was already dead.
  logic [31:0] flush_cnt_q;
  logic        discard;
  assign discard     = redirect_valid_i & ((cnt_after_pop != '0) | (state_q == REQ));
  assign flush_cnt_o = flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      flush_cnt_q <= '0;
    else if (discard) flush_cnt_q <= flush_cnt_q + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed table-driven bench for ifetch_queue; rows with rst=1 pulse reset mid-cycle
// and check the asynchronous reset values before any clock edge.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ins_ready = 1'b0;
  logic        ins_valid;
  logic [31:0] ins_data, ins_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef IFETCH_PERF_EN
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .ins_ready_i(ins_ready), .ins_valid_o(ins_valid),
    .ins_data_o(ins_data), .ins_pc_o(ins_pc),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
`ifdef IFETCH_PERF_EN
    , .flush_cnt_o(flush_cnt)
`endif
  );

  typedef struct {
    bit          rst;
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          ack;
    logic [31:0] rdata;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_data;
    bit          e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input bit rst, input bit rv, input logic [31:0] rpc,
                     input bit rdy, input bit ack, input logic [31:0] rdata,
                     input bit ev, input logic [31:0] epc, input logic [31:0] ed,
                     input bit ereq, input logic [31:0] eaddr);
    vec_t v;
    v = '{rst, rv, rpc, rdy, ack, rdata, ev, epc, ed, ereq, eaddr};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //   rst rv rpc           rdy ack rdata          v pc            data           req addr
    // streaming after reset; ack in IDLE is ignored
    row(1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        32'h0,         0, 32'h0);
    row(0, 0, 32'h0,        1, 1, 32'hDEAD_BEEF, 0, 32'h0,        32'h0,         1, 32'h0);
    row(0, 0, 32'h0,        1, 1, 32'hD000_0000, 1, 32'h0,        32'hD000_0000, 1, 32'h4);
    row(0, 0, 32'h0,        1, 1, 32'hD000_0004, 1, 32'h4,        32'hD000_0004, 1, 32'h8);
    row(0, 0, 32'h0,        1, 1, 32'hD000_0008, 1, 32'h8,        32'hD000_0008, 1, 32'hC);
    // fill to DEPTH with ins_ready low
    row(1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        32'h0,         0, 32'h0);
    row(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        32'h0,         1, 32'h0);
    row(0, 0, 32'h0,        0, 1, 32'hA000_0000, 1, 32'h0,        32'hA000_0000, 1, 32'h4);
    row(0, 0, 32'h0,        0, 1, 32'hA000_0004, 1, 32'h0,        32'hA000_0000, 1, 32'h8);
    row(0, 0, 32'h0,        0, 1, 32'hA000_0008, 1, 32'h0,        32'hA000_0000, 1, 32'hC);
    row(0, 0, 32'h0,        0, 1, 32'hA000_000C, 1, 32'h0,        32'hA000_0000, 0, 32'hC);
    row(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        32'hA000_0000, 0, 32'hC);
    row(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h4,        32'hA000_0004, 1, 32'h10);
    // redirect to 0x103 while 0x10 pending; ack three cycles later is dropped
    row(0, 1, 32'h103,      0, 0, 32'h0,         0, 32'h0,        32'h0,         1, 32'h10);
    row(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        32'h0,         1, 32'h10);
    row(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        32'h0,         1, 32'h10);
    row(0, 0, 32'h0,        0, 1, 32'hBAD0_BAD0, 0, 32'h0,        32'h0,         0, 32'h10);
    row(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        32'h0,         1, 32'h100);
    row(0, 0, 32'h0,        0, 1, 32'hC000_0100, 1, 32'h100,      32'hC000_0100, 1, 32'h104);
    // redirect + ack + pop on one edge
    row(0, 1, 32'h40,       1, 1, 32'hBAD1_BAD1, 0, 32'h0,        32'h0,         0, 32'h104);
    row(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        32'h0,         1, 32'h40);
    // wrap-around fetch
    row(0, 1, 32'hFFFF_FFFC,1, 0, 32'h0,         0, 32'h0,        32'h0,         1, 32'h40);
    row(0, 0, 32'h0,        1, 1, 32'hBAD2_BAD2, 0, 32'h0,        32'h0,         0, 32'h40);
    row(0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        32'h0,         1, 32'hFFFF_FFFC);
    row(0, 0, 32'h0,        1, 1, 32'hE000_0000, 1, 32'hFFFF_FFFC,32'hE000_0000, 1, 32'h0);
    row(0, 0, 32'h0,        1, 1, 32'hE000_0001, 1, 32'h0,        32'hE000_0001, 1, 32'h4);
    // build 3 entries + pending read, then reset mid-request
    row(0, 0, 32'h0,        0, 1, 32'hE000_0002, 1, 32'h0,        32'hE000_0001, 1, 32'h8);
    row(0, 0, 32'h0,        0, 1, 32'hE000_0003, 1, 32'h0,        32'hE000_0001, 1, 32'hC);
    row(1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        32'h0,         0, 32'h0);
    row(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        32'h0,         1, 32'h0);
    row(0, 0, 32'h0,        1, 1, 32'hF000_0000, 1, 32'h0,        32'hF000_0000, 1, 32'h4);

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      ins_ready      = v.rdy;
      mem_ack        = v.ack;
      mem_rdata      = v.rdata;
      if (v.rst) begin
        rst_n = 1'b0;
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("row%0d ins_valid", i), {31'b0, ins_valid}, {31'b0, v.e_valid});
      chk($sformatf("row%0d ins_pc", i),    ins_pc,             v.e_pc);
      chk($sformatf("row%0d ins_data", i),  ins_data,           v.e_data);
      chk($sformatf("row%0d mem_req", i),   {31'b0, mem_req},   {31'b0, v.e_req});
      chk($sformatf("row%0d mem_addr", i),  mem_addr,           v.e_addr);
`ifdef IFETCH_PERF_EN
      if (i == 27) chk("flush_cnt", flush_cnt, 32'd3);
      if (v.rst)   chk($sformatf("row%0d flush_cnt reset", i), flush_cnt, 32'd0);
`endif
      if (v.rst) rst_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
